// File: rtl/display_source_selector.sv
// Picks one of four processor observation values with a debounced "next page" button
// and presents it as a 13-bit display number, refreshed periodically unless frozen.
module display_source_selector #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        freeze_sw,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] alu_result,
  input  logic [31:0] rf_data,
  output logic [1:0]  page,
  output logic [3:0]  page_led,
  output logic [12:0] num,
  output logic        sat_flag
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_CNT, PRESSED, RELEASE_CNT} db_state_t;

  logic            btn_m, btn_s, frz_m, frz_s;
  db_state_t       db_state;
  logic [DW-1:0]   db_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            load_pending;
  logic            next_pulse, hold_tc, do_load;
  logic [12:0]     sel_num;
  logic            sel_sat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      frz_m <= 1'b0;
      frz_s <= 1'b0;
    end else begin
      btn_m <= btn_next;
      btn_s <= btn_m;
      frz_m <= freeze_sw;
      frz_s <= frz_m;
    end
  end

  // The press is accepted on the edge that leaves PRESS_CNT; page advances on that same edge.
  assign next_pulse = (db_state == PRESS_CNT) && btn_s && (db_cnt == DB_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      db_state <= IDLE;
      db_cnt   <= '0;
    end else begin
      unique case (db_state)
        IDLE: if (btn_s) begin
          db_state <= PRESS_CNT;
          db_cnt   <= '0;
        end
        PRESS_CNT: begin
          if (!btn_s)                db_state <= IDLE;
          else if (db_cnt == DB_LAST) db_state <= PRESSED;
          else                       db_cnt   <= db_cnt + 1'b1;
        end
        PRESSED: if (!btn_s) begin
          db_state <= RELEASE_CNT;
          db_cnt   <= '0;
        end
        RELEASE_CNT: begin
          if (btn_s)                 db_state <= PRESSED;
          else if (db_cnt == DB_LAST) db_state <= IDLE;
          else                       db_cnt   <= db_cnt + 1'b1;
        end
        default: db_state <= IDLE;
      endcase
    end
  end

  function automatic void clamp13(input logic [31:0] v, output logic [12:0] n, output logic s);
    s = |v[31:13];
    n = s ? 13'h1FFF : v[12:0];
  endfunction

  always_comb begin
    sel_num = '0;
    sel_sat = 1'b0;
    unique case (page)
      2'd0: sel_num = pc[14:2];
      2'd1: sel_num = instr[12:0];
      2'd2: clamp13(alu_result, sel_num, sel_sat);
      2'd3: clamp13(rf_data, sel_num, sel_sat);
      default: sel_num = '0;
    endcase
  end

  assign hold_tc = (hold_cnt == HOLD_LAST);
  assign do_load = load_pending && !frz_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      page         <= 2'd0;
      page_led     <= 4'b0001;
      num          <= '0;
      sat_flag     <= 1'b0;
      hold_cnt     <= '0;
      load_pending <= 1'b1;
    end else begin
      if (next_pulse) begin
        page     <= page + 2'd1;
        page_led <= {page_led[2:0], page_led[3]};
      end
      // A load restarts the refresh period, so a coincident terminal count is absorbed.
      if (do_load) begin
        num      <= sel_num;
        sat_flag <= sel_sat;
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_tc ? '0 : hold_cnt + 1'b1;
      end
      load_pending <= next_pulse || (hold_tc && !do_load) || (load_pending && !do_load);
    end
  end

endmodule

// File: tb/tb_display_source_selector.sv
// Randomized scoreboard bench for display_source_selector with a page/value reference model.
module tb_display_source_selector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_next = 1'b0;
  logic        freeze_sw = 1'b0;
  logic [31:0] pc = '0, instr = '0, alu_result = '0, rf_data = '0;
  logic [1:0]  page;
  logic [3:0]  page_led;
  logic [12:0] num;
  logic        sat_flag;

  display_source_selector #(.DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .freeze_sw(freeze_sw),
    .pc(pc), .instr(instr), .alu_result(alu_result), .rf_data(rf_data),
    .page(page), .page_led(page_led), .num(num), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  typedef struct {
    int          cyc;
    string       name;
    int          pg;
    logic [12:0] n;
    logic        s;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int errors = 0;
  int ref_page = 0;

  // Reference: the value a page shows, from the plain numeric rules.
  function automatic void model_sel(input int pg, output logic [12:0] n, output logic s);
    longint v;
    s = 1'b0;
    case (pg)
      0:       v = (longint'(pc) / 4) % 8192;
      1:       v = longint'(instr) % 8192;
      2:       v = longint'(alu_result);
      default: v = longint'(rf_data);
    endcase
    if (v > 8191) begin
      n = 13'd8191;
      s = 1'b1;
    end else begin
      n = 13'(v);
    end
  endfunction

  function automatic void chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cycle) begin
      e = q.pop_front();
      chk({e.name, ".page"}, int'(page), e.pg);
      chk({e.name, ".page_led"}, int'(page_led), 1 << e.pg);
      chk({e.name, ".num"}, int'(num), int'(e.n));
      chk({e.name, ".sat_flag"}, int'(sat_flag), int'(e.s));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string name, input int pg, input logic [12:0] n, input logic s);
    exp_t x;
    x.cyc = cycle; x.name = name; x.pg = pg; x.n = n; x.s = s;
    q.push_back(x);
  endtask

  task automatic push_model(input string name);
    logic [12:0] n;
    logic s;
    model_sel(ref_page, n, s);
    push_exp(name, ref_page, n, s);
  endtask

  // Long presses (>=10 cycles) are accepted, short ones (<=3) are glitches.
  task automatic press(input int len);
    btn_next = 1'b1;
    step(len);
    btn_next = 1'b0;
    step(20);
    if (len >= 10) ref_page = (ref_page + 1) % 4;
  endtask

  task automatic goto_page(input int pg);
    while (ref_page != pg) press(12);
  endtask

  initial begin
    logic [12:0] shown;
    logic        shown_s;
    int          len;

    pc = 32'h0000_0010;
    step(3);
    push_exp("reset", 0, 13'd0, 1'b0);
    rst = 1'b1;
    step(1);
    push_exp("first_load", 0, 13'd4, 1'b0);

    instr = 32'h0000_1ABC;
    press(20);
    push_exp("held_press", 1, 13'h1ABC, 1'b0);
    press(2);
    push_exp("short_pulse", 1, 13'h1ABC, 1'b0);

    for (int i = 0; i < 12; i++) begin
      pc = $urandom; instr = $urandom; rf_data = $urandom;
      alu_result = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 16383));
      len = ($urandom_range(0, 2) != 0) ? $urandom_range(10, 20) : $urandom_range(1, 3);
      press(len);
      push_model("random");
    end

    goto_page(3);
    for (int i = 0; i < 4; i++) begin
      press(12);
      push_model("wrap");
    end

    goto_page(2);
    alu_result = 32'h0000_2000;
    step(10);
    push_exp("alu_sat", 2, 13'd8191, 1'b1);
    alu_result = 32'h0000_1FFF;
    step(10);
    push_exp("alu_max", 2, 13'd8191, 1'b0);

    model_sel(ref_page, shown, shown_s);
    freeze_sw = 1'b1;
    step(3);
    alu_result = $urandom; rf_data = $urandom | 32'h0001_0000; pc = $urandom;
    press(15);
    push_exp("frozen_a", ref_page, shown, shown_s);
    step(15);
    push_exp("frozen_b", ref_page, shown, shown_s);
    freeze_sw = 1'b0;
    step(3);
    push_model("unfreeze");

    if (ref_page == 0) press(12);
    btn_next = 1'b1;
    step(4);
    rst = 1'b0;
    btn_next = 1'b0;
    step(1);
    push_exp("mid_reset", 0, 13'd0, 1'b0);
    step(3);
    rst = 1'b1;
    ref_page = 0;
    step(20);
    push_model("after_reset");

    for (int i = 0; i < 10 && q.size() > 0; i++) step(1);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
